user_extern_initiator: RTL

- Initiator-side bridge for the VNP4 user-extern protocol: accepts single-beat requests on an AXIS slave, drives a user-extern request port (data + 1-cycle valid), and collects the in-order responses onto an AXIS master.
- Lets RTL exercise extern responders (ipv4_checksum_verify, ipv4_checksum_update, future externs) without a VNP4 instance. Used in-system for CPU-driven self-test and as the bench driver for extern responders.
- Credit-limited so that the non-backpressurable response path can never overflow. A watchdog synthesizes an error response for any lost reply.

---
 rtl/p4_router_pkg.sv | 17 +
 rtl/user_extern_resp_fifo.sv | 67 ++++++
 rtl/user_extern_initiator.sv | 112 +++++++++++
 3 files changed

// File: rtl/p4_router_pkg.sv
// Shared types and constants for the p4_router extern-facing blocks.
package p4_router_pkg;

  localparam int UE_RESP_ERR_BIT     = 0;
  localparam int UE_IN_DATA_BITS_DEF = 16;

  // FIFO entries are stored with this layout: err in the MSB, data below.
  typedef struct packed {
    logic                           err;
    logic [UE_IN_DATA_BITS_DEF-1:0] data;
  } user_extern_resp_t;

  function automatic int bytes_of(input int bits);
    return (bits + 7) / 8;
  endfunction

endpackage

// File: rtl/user_extern_resp_fifo.sv
// First-word-fall-through sync FIFO whose head sits in an output register.
// A push into an empty FIFO is visible on o_vld the next cycle.
module user_extern_resp_fifo #(
  parameter int W     = 17,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push_vld,
  input  logic [W-1:0] i_push_dat,
  output logic         o_vld,
  output logic [W-1:0] o_dat,
  input  logic         i_rdy
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          r_vld;
  logic [W-1:0]  r_dat;

  logic w_out_free;
  logic w_mem_empty;
  logic w_mem_pop;
  logic w_mem_push;

  assign w_out_free  = !r_vld || i_rdy;
  assign w_mem_empty = (r_count == '0);
  assign w_mem_pop   = w_out_free && !w_mem_empty;
  // Bypass the storage when the output register is free and nothing is queued.
  assign w_mem_push  = i_push_vld && !(w_out_free && w_mem_empty);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld    <= 1'b0;
      r_dat    <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_out_free) begin
        if (!w_mem_empty) begin
          r_vld <= 1'b1;
          r_dat <= r_mem[r_rd_ptr];
        end else if (i_push_vld) begin
          r_vld <= 1'b1;
          r_dat <= i_push_dat;
        end else begin
          r_vld <= 1'b0;
        end
      end
      if (w_mem_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_mem_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + (AW+1)'(w_mem_push) - (AW+1)'(w_mem_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_mem_push) r_mem[r_wr_ptr] <= i_push_dat;
  end

  assign o_vld = r_vld;
  assign o_dat = r_dat;

endmodule

// File: rtl/user_extern_initiator.sv
// Initiator bridge: AXIS requests -> user-extern strobe, in-order extern replies -> AXIS.
// Credit-limited so the unstallable reply path never overflows; a watchdog fills in lost replies.
module user_extern_initiator
  import p4_router_pkg::*;
#(
  parameter int UE_OUT_DATA_BITS = 160,
  parameter int UE_IN_DATA_BITS  = 16,
  parameter int MAX_OUTSTANDING  = 4,
  parameter int TIMEOUT_CYCLES   = 1024,
  localparam int REQ_BYTES  = bytes_of(UE_OUT_DATA_BITS),
  localparam int RESP_BYTES = bytes_of(UE_IN_DATA_BITS),
  localparam int CW         = $clog2(MAX_OUTSTANDING) + 1,
  localparam int WDW        = $clog2(TIMEOUT_CYCLES)
) (
  input  logic                        clk,
  input  logic                        aresetn,
  input  logic                        req_tvalid,
  output logic                        req_tready,
  input  logic [REQ_BYTES*8-1:0]      req_tdata,
  input  logic [REQ_BYTES-1:0]        req_tkeep,
  input  logic                        req_tlast,
  output logic                        resp_tvalid,
  input  logic                        resp_tready,
  output logic [RESP_BYTES*8-1:0]     resp_tdata,
  output logic [RESP_BYTES-1:0]       resp_tkeep,
  output logic                        resp_tlast,
  output logic [0:0]                  resp_tuser,
  output logic [UE_OUT_DATA_BITS-1:0] user_extern_data_out,
  output logic                        user_extern_valid_out,
  input  logic [UE_IN_DATA_BITS-1:0]  user_extern_data_in,
  input  logic                        user_extern_valid_in,
  output logic [CW-1:0]               outstanding,
  output logic                        timeout_event,
  output logic                        unexpected_resp_event
);
  logic [CW-1:0]               r_credits;
  logic [CW-1:0]               r_pending;
  logic [WDW-1:0]              r_wd;
  logic                        r_valid_out;
  logic [UE_OUT_DATA_BITS-1:0] r_data_out;

  logic                     w_issue;
  logic                     w_pend_nz;
  logic                     w_capture;
  logic                     w_timeout;
  logic                     w_resp_hs;
  logic                     w_push_vld;
  logic [UE_IN_DATA_BITS:0] w_push_dat;
  logic                     w_fifo_vld;
  logic [UE_IN_DATA_BITS:0] w_fifo_dat;
  logic                     w_unused_req;

  assign req_tready = (r_credits < CW'(MAX_OUTSTANDING));
  assign w_issue    = req_tvalid && req_tready;
  assign w_pend_nz  = (r_pending != '0);
  assign w_capture  = user_extern_valid_in && w_pend_nz;
  // A real reply in the expiry cycle wins over the synthesized error.
  assign w_timeout  = w_pend_nz && !user_extern_valid_in && (r_wd == WDW'(TIMEOUT_CYCLES - 1));
  assign w_resp_hs  = w_fifo_vld && resp_tready;

  assign w_push_vld = w_capture || w_timeout;
  assign w_push_dat = w_timeout ? {1'b1, {UE_IN_DATA_BITS{1'b0}}} : {1'b0, user_extern_data_in};

  user_extern_resp_fifo #(
    .W     (UE_IN_DATA_BITS + 1),
    .DEPTH (MAX_OUTSTANDING)
  ) u_resp_fifo (
    .clk        (clk),
    .rst_n      (aresetn),
    .i_push_vld (w_push_vld),
    .i_push_dat (w_push_dat),
    .o_vld      (w_fifo_vld),
    .o_dat      (w_fifo_dat),
    .i_rdy      (resp_tready)
  );

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_credits   <= '0;
      r_pending   <= '0;
      r_wd        <= '0;
      r_valid_out <= 1'b0;
      r_data_out  <= '0;
    end else begin
      r_credits   <= r_credits + CW'(w_issue) - CW'(w_resp_hs);
      r_pending   <= r_pending + CW'(w_issue) - CW'(w_push_vld);
      r_valid_out <= w_issue;
      if (w_issue) r_data_out <= req_tdata[UE_OUT_DATA_BITS-1:0];
      if (w_push_vld || (w_issue && !w_pend_nz)) r_wd <= '0;
      else if (w_pend_nz)                         r_wd <= r_wd + 1'b1;
    end
  end

  always_comb begin
    resp_tuser                  = '0;
    resp_tuser[UE_RESP_ERR_BIT] = w_fifo_dat[UE_IN_DATA_BITS];
  end

  assign resp_tvalid           = w_fifo_vld;
  assign resp_tdata            = (RESP_BYTES*8)'(w_fifo_dat[UE_IN_DATA_BITS-1:0]);
  assign resp_tkeep            = '1;
  assign resp_tlast            = 1'b1;
  assign user_extern_data_out  = r_data_out;
  assign user_extern_valid_out = r_valid_out;
  assign outstanding           = r_credits;
  assign timeout_event         = w_timeout;
  assign unexpected_resp_event = user_extern_valid_in && !w_pend_nz;

  // Every beat is a whole request, so framing sidebands carry no information.
  assign w_unused_req = ^{req_tkeep, req_tlast, req_tdata};

endmodule
